// File: rtl/sram_like_mem_responder.sv
// sram_like_mem_responder: responder end of the sram-like req/addr_ok/data_ok
// bus. A word-addressed memory sits behind the bus. Accepted requests are
// queued in order, each with its own latency countdown. Responses come out
// oldest first. An optional LFSR drops addr_ok pseudo-randomly.
module sram_like_mem_responder #(
  parameter int AW       = 10,
  parameter int LATENCY  = 2,
  parameter int DEPTH    = 4,
  parameter int STALL_EN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] CD_LOAD = 4'(LATENCY - 1);

  // Backing store and response queue payload: neither is reset.
  logic [31:0]   mem      [2**AW];
  logic [31:0]   ent_data [DEPTH];
  logic [3:0]    ent_cd   [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [7:0]    lfsr;

  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          stall_ok;
  logic [AW-1:0] widx;
  logic [3:0]    mask;
  logic          unused_addr;

  // Lane enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign widx        = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0] & 2'b00};
  assign mask        = byte_mask(size, addr[1:0]);

  // Queue status, acceptance and response drive.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    pop      = ~empty & (ent_cd[rptr] == 4'd0);
    stall_ok = (STALL_EN == 0) | lfsr[0];
    addr_ok  = ~rst & (~full | pop) & stall_ok;
    push     = req & addr_ok;
    data_ok  = pop;
    rdata    = pop ? ent_data[rptr] : 32'h0;
  end

  // Control state: pointers, occupancy, countdowns and stall LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      lfsr  <= 8'hA5;
      for (int i = 0; i < DEPTH; i++) ent_cd[i] <= 4'd0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      count <= count + CW'(push) - CW'(pop);
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wptr == PW'(i)))
          ent_cd[i] <= CD_LOAD;
        else if (ent_cd[i] != 4'd0)
          ent_cd[i] <= ent_cd[i] - 4'd1;
      end
    end
  end

  // Write commits masked lanes at the acceptance edge.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read data is captured into the queue at acceptance; write acks carry zero.
  always_ff @(posedge clk) begin
    if (push) ent_data[wptr] <= wr ? 32'h0 : mem[widx];
  end

endmodule
